multiword_add_sequencer: RTL and testbench

- Sequential front end for the 8-bit conditional-sum adder, one instance inside this block.
- Accepts wide operand pairs over a valid/ready handshake.
- Feeds the adder one byte per cycle, LSB first, and chains each byte's cout into the next byte's cin.
- Returns a WORDS*8-bit sum or difference, with carry and signed-overflow flags, over a second valid/ready handshake.

---
 rtl/multiword_add_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Multi-byte add/subtract sequencer built around one 8-bit conditional-sum adder.
// Operands are accepted over a valid/ready handshake. The block adds them one byte
// per cycle, least significant byte first, and chains the carry between bytes.
// The result is returned with carry and signed-overflow flags over a second
// valid/ready handshake.

// 8-bit conditional-sum adder: each bit-group keeps a sum and carry for both
// possible carry-ins, and adjacent groups are merged by selecting with the lower
// group's carry.
module cond_sum_adder8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   function automatic logic [8:0] cs_add8(input logic [7:0] a_v,
                                          input logic [7:0] b_v,
                                          input logic       cin_v);
      logic [7:0] s0;
      logic [7:0] s1;
      logic [7:0] c0;
      logic [7:0] c1;
      logic       t0;
      logic       t1;
      logic [2:0] lo_i;
      logic [2:0] hi_i;
      logic [2:0] bit_i;
      // Single-bit groups: sum and carry-out for carry-in 0 and for carry-in 1.
      s0 = a_v ^ b_v;
      s1 = ~(a_v ^ b_v);
      c0 = a_v & b_v;
      c1 = a_v | b_v;
      // Merge pairs of groups: 1 -> 2 -> 4 -> 8 bits. Group carries are stored at
      // the group's lowest bit position.
      for (int g = 1; g < 8; g = g * 2) begin
         for (int lo = 0; lo < 8; lo = lo + 2 * g) begin
            lo_i = 3'(lo);
            hi_i = 3'(lo + g);
            for (int k = 0; k < g; k++) begin
               bit_i     = 3'(lo + g + k);
               t0        = c0[lo_i] ? s1[bit_i] : s0[bit_i];
               t1        = c1[lo_i] ? s1[bit_i] : s0[bit_i];
               s0[bit_i] = t0;
               s1[bit_i] = t1;
            end
            t0       = c0[lo_i] ? c1[hi_i] : c0[hi_i];
            t1       = c1[lo_i] ? c1[hi_i] : c0[hi_i];
            c0[lo_i] = t0;
            c1[lo_i] = t1;
         end
      end
      return cin_v ? {c1[0], s1} : {c0[0], s0};
   endfunction

   logic [8:0] add_s;

   // Final selection by the real carry-in.
   always_comb begin
      add_s = cs_add8(a, b, cin);
   end

   assign sum  = add_s[7:0];
   assign cout = add_s[8];

endmodule

module multiword_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*WORDS-1:0] op_a,
   input  logic [8*WORDS-1:0] op_b,
   input  logic               op_sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*WORDS-1:0] result,
   output logic               carry_out,
   output logic               overflow
);

   localparam int W     = 8 * WORDS;
   localparam int IDX_W = $clog2(WORDS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [1:0]       state_r;
   logic [IDX_W-1:0] idx_r;
   logic             carry_r;
   logic [W-1:0]     a_reg_r;
   logic [W-1:0]     b_reg_r;
   logic [W-1:0]     result_r;
   logic             carry_out_r;
   logic             overflow_r;

   logic [7:0]       a_byte_s;
   logic [7:0]       b_byte_s;
   logic [7:0]       sum_s;
   logic             cout_s;

   // Byte lane selected by the current index; b_reg_r already holds ~B for a subtract.
   always_comb begin
      a_byte_s = a_reg_r[{idx_r, 3'b000} +: 8];
      b_byte_s = b_reg_r[{idx_r, 3'b000} +: 8];
   end

   cond_sum_adder8 u_adder (
      .a    (a_byte_s),
      .b    (b_byte_s),
      .cin  (carry_r),
      .sum  (sum_s),
      .cout (cout_s)
   );

   // Handshake flags decode straight from the state register, so a reset clears
   // out_valid and raises in_ready at once, without waiting for a clock edge.
   always_comb begin
      in_ready  = (state_r == ST_IDLE);
      out_valid = (state_r == ST_DONE);
   end

   assign result    = result_r;
   assign carry_out = carry_out_r;
   assign overflow  = overflow_r;

   // Sequencer: latch the operands, run one byte per cycle, then hold the result
   // until the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         idx_r       <= '0;
         carry_r     <= 1'b0;
         a_reg_r     <= '0;
         b_reg_r     <= '0;
         result_r    <= '0;
         carry_out_r <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  a_reg_r <= op_a;
                  b_reg_r <= op_sub ? ~op_b : op_b;
                  carry_r <= op_sub;
                  idx_r   <= '0;
                  state_r <= ST_ADD;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ADD: begin
               result_r[{idx_r, 3'b000} +: 8] <= sum_s;
               carry_r                        <= cout_s;
               if (idx_r == LAST_IDX) begin
                  // Signed overflow: the carry into the MSB differs from the carry out of it.
                  carry_out_r <= cout_s;
                  overflow_r  <= cout_s ^ (a_reg_r[W-1] ^ b_reg_r[W-1] ^ sum_s[7]);
                  idx_r       <= '0;
                  state_r     <= ST_DONE;
               end else begin
                  idx_r   <= idx_r + IDX_ONE;
                  state_r <= ST_ADD;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               idx_r   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed testbench for multiword_add_sequencer with WORDS=4 (32-bit operands).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_multiword_add_sequencer;

   localparam int WORDS = 4;
   localparam int W     = 32;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   int checks_cnt;
   int fail_cnt;

   multiword_add_sequencer #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value and count the result.
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present an operand pair in IDLE and return at the falling edge after the accept edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      @(negedge clk);
      check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      op_sub   = sub;
      @(posedge clk);
      @(negedge clk);
      // Scramble the operands: they must have been captured on the accept edge.
      in_valid = 1'b0;
      op_a     = 32'hDEAD_BEEF;
      op_b     = 32'h1234_5678;
      op_sub   = ~sub;
   endtask

   // Wait (bounded) for out_valid, check the latency and the returned values.
   task automatic wait_result(input string tag, input logic [W-1:0] exp_res,
                              input logic exp_c, input logic exp_v);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_latency"}, 32'(n), 32'd4);
      check_val({tag, "_result"}, result, exp_res);
      check_val({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
      check_val({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_v});
      check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
   endtask

   // Complete the output handshake and check the return to IDLE.
   task automatic finish_op(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check_val({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check_val({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] held_res;
      logic         held_c;
      logic         held_v;
      checks_cnt = 0;
      fail_cnt   = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      op_a       = '0;
      op_b       = '0;
      op_sub     = 1'b0;
      out_ready  = 1'b0;
      #12;
      check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("rst_result", result, 32'd0);
      check_val("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Carry across a byte boundary.
      start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
      wait_result("byte_carry", 32'h0000_0100, 1'b0, 1'b0);
      finish_op("byte_carry");

      // Full wrap-around.
      start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      wait_result("wrap", 32'h0000_0000, 1'b1, 1'b0);
      finish_op("wrap");

      // Signed overflow, positive and negative.
      start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      wait_result("ovf_pos", 32'h8000_0000, 1'b0, 1'b1);
      finish_op("ovf_pos");
      start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
      wait_result("ovf_neg", 32'h0000_0000, 1'b1, 1'b1);
      finish_op("ovf_neg");

      // Subtract cases.
      start_op(32'd5, 32'd7, 1'b1);
      wait_result("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0);
      finish_op("sub_borrow");
      start_op(32'd7, 32'd5, 1'b1);
      wait_result("sub_pos", 32'h0000_0002, 1'b1, 1'b0);
      finish_op("sub_pos");
      start_op(32'h8000_0000, 32'h0000_0001, 1'b1);
      wait_result("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
      finish_op("sub_ovf");

      // Backpressure: hold in DONE while a new pair is offered.
      start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
      wait_result("bp_first", 32'h2345_6789, 1'b0, 1'b0);
      held_res = result;
      held_c   = carry_out;
      held_v   = overflow;
      in_valid = 1'b1;
      op_a     = 32'h0000_FFFF;
      op_b     = 32'h0000_0001;
      op_sub   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("bp_hold_result", result, 32'h2345_6789);
         check_val("bp_hold_flags", {30'd0, carry_out, overflow}, {30'd0, held_c, held_v});
         check_val("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         check_val("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
      end
      check_val("bp_held_snapshot", held_res, 32'h2345_6789);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check_val("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      op_a     = 32'hDEAD_BEEF;
      check_val("bp_accepted", {31'd0, in_ready}, 32'd0);
      wait_result("bp_second", 32'h0001_0000, 1'b0, 1'b0);
      finish_op("bp_second");

      // Asynchronous reset two cycles into ADD.
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_val("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("mid_rst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      start_op(32'd1, 32'd2, 1'b0);
      wait_result("post_rst", 32'd3, 1'b0, 1'b0);
      finish_op("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
